// File: rtl/mest_pro_pkg.sv
// Shared definitions for the MEST Pro instruction sequencer:
// state encoding, instruction field widths and memory-access opcodes.
package mest_pro_pkg;

  localparam int OPCODE_SIZE   = 8;
  localparam int OPERANDA_SIZE = 8;
  localparam int OPERANDB_SIZE = 8;

  localparam logic [OPCODE_SIZE-1:0] OP_LOAD_WORD  = 8'h0D;
  localparam logic [OPCODE_SIZE-1:0] OP_STORE_WORD = 8'h0E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_MEMW,
    S_UPDATE,
    S_HALT
  } seq_state_t;

  // Instructions that must wait for the main-memory port before the PC moves on.
  function automatic logic is_mem_op(input logic [OPCODE_SIZE-1:0] opc);
    return (opc == OP_LOAD_WORD) || (opc == OP_STORE_WORD);
  endfunction

endpackage

// File: rtl/mest_pro_ret_stack.sv
// Return-address LIFO. Only the pointer is reset; entry storage is plain
// registers so the array can map onto distributed RAM.
module mest_pro_ret_stack
  import mest_pro_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         i_reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [AW-1:0]    top_idx;

  // The pointer counts entries, so it needs one bit more than the address.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

  assign full    = (ptr == PTR_W'(DEPTH));
  assign empty   = (ptr == '0);
  assign top_idx = ptr[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

endmodule

// File: rtl/mest_pro_seq.sv
// MEST Pro instruction sequencer: fetch, decode, execute handshake, memory
// stall and PC resolution (sequential / call / return / halt).
module mest_pro_seq
  import mest_pro_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int OPC_W       = OPCODE_SIZE,
  parameter int OPA_W       = OPERANDA_SIZE,
  parameter int OPB_W       = OPERANDB_SIZE,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  output logic                         o_imem_req,
  output logic [PC_W-1:0]              o_imem_addr,
  input  logic                         i_imem_ack,
  input  logic [OPC_W+OPA_W+OPB_W-1:0] i_imem_data,
  output logic [OPC_W-1:0]             o_op_code,
  output logic [OPA_W-1:0]             o_operand1,
  output logic [OPB_W-1:0]             o_operand2,
  output logic                         o_execute,
  input  logic                         i_exec_done,
  input  logic                         i_jump,
  input  logic                         i_return_pc,
  input  logic                         i_end_of_code,
  input  logic                         i_mm_busy,
  output logic [PC_W-1:0]              o_pc,
  output logic                         o_busy,
  output logic                         o_halted,
  output logic                         o_stack_err
);

  seq_state_t      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            jump_flag;
  logic            ret_flag;
  logic            end_flag;

  logic            stk_push;
  logic            stk_pop;
  logic            stk_clear;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_top;

  assign pc_inc      = pc + PC_W'(1);
  assign o_pc        = pc;
  assign o_imem_addr = pc;

  // Stack strobes follow the UPDATE priority, so push and pop are exclusive.
  assign stk_push  = (state == S_UPDATE) && !end_flag && !ret_flag && jump_flag && !stk_full;
  assign stk_pop   = (state == S_UPDATE) && !end_flag && ret_flag && !stk_empty;
  assign stk_clear = ((state == S_IDLE) || (state == S_HALT)) && i_start;

  mest_pro_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .din       (pc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      o_op_code   <= '0;
      o_operand1  <= '0;
      o_operand2  <= '0;
      jump_flag   <= 1'b0;
      ret_flag    <= 1'b0;
      end_flag    <= 1'b0;
      o_imem_req  <= 1'b0;
      o_execute   <= 1'b0;
      o_busy      <= 1'b0;
      o_halted    <= 1'b0;
      o_stack_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            state       <= S_FETCH;
            pc          <= '0;
            o_stack_err <= 1'b0;
            o_imem_req  <= 1'b1;
            o_busy      <= 1'b1;
            o_halted    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            {o_op_code, o_operand1, o_operand2} <= i_imem_data;
            o_imem_req <= 1'b0;
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          o_execute <= 1'b1;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          o_execute <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_exec_done) begin
            jump_flag <= i_jump;
            ret_flag  <= i_return_pc;
            end_flag  <= i_end_of_code;
            state     <= is_mem_op(OPCODE_SIZE'(o_op_code)) ? S_MEMW : S_UPDATE;
          end
        end
        S_MEMW: begin
          if (!i_mm_busy) begin
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (end_flag || (ret_flag && stk_empty) || (!ret_flag && jump_flag && stk_full)) begin
            // Halting leaves the PC on the offending instruction.
            state    <= S_HALT;
            o_busy   <= 1'b0;
            o_halted <= 1'b1;
            if (!end_flag) begin
              o_stack_err <= 1'b1;
            end
          end else begin
            state      <= S_FETCH;
            o_imem_req <= 1'b1;
            if (ret_flag) begin
              pc <= stk_top;
            end else if (jump_flag) begin
              pc <= PC_W'(o_operand1);
            end else begin
              pc <= pc_inc;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mest_pro_seq.sv
// Directed bench for mest_pro_seq: an instruction-memory / execute-unit /
// main-memory responder, plus a fetch-address scoreboard.
module tb_mest_pro_seq;
  import mest_pro_pkg::*;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_JMP = 8'h20;
  localparam logic [7:0] OP_RET = 8'h21;
  localparam logic [7:0] OP_END = 8'hFF;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic        i_imem_ack;
  logic [23:0] i_imem_data;
  logic [7:0]  o_op_code;
  logic [7:0]  o_operand1;
  logic [7:0]  o_operand2;
  logic        o_execute;
  logic        i_exec_done;
  logic        i_jump;
  logic        i_return_pc;
  logic        i_end_of_code;
  logic        i_mm_busy;
  logic [7:0]  o_pc;
  logic        o_busy;
  logic        o_halted;
  logic        o_stack_err;

  always #5 clk = ~clk;

  mest_pro_seq dut (
    .clk           (clk),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_data   (i_imem_data),
    .o_op_code     (o_op_code),
    .o_operand1    (o_operand1),
    .o_operand2    (o_operand2),
    .o_execute     (o_execute),
    .i_exec_done   (i_exec_done),
    .i_jump        (i_jump),
    .i_return_pc   (i_return_pc),
    .i_end_of_code (i_end_of_code),
    .i_mm_busy     (i_mm_busy),
    .o_pc          (o_pc),
    .o_busy        (o_busy),
    .o_halted      (o_halted),
    .o_stack_err   (o_stack_err)
  );

  logic [23:0] imem [256];
  int          ack_limit  = 256;
  int          store_busy = 4;
  int          cyc        = 0;
  int          mm_cnt     = 0;
  bit          exec_seen  = 0;
  int          exec_count = 0;
  logic        req_prev   = 1'b0;
  int          n_total    = 0;
  int          n_pass     = 0;
  logic [7:0]  exp_q [$];
  int          fetch_t [$];

  always @(posedge clk) cyc++;

  // Responder: same-cycle fetch ack, done one cycle after execute, store stalls.
  always @(negedge clk) begin
    if (o_imem_req && (int'(o_imem_addr) < ack_limit)) begin
      i_imem_ack  = 1'b1;
      i_imem_data = imem[o_imem_addr];
    end else begin
      i_imem_ack  = 1'b0;
    end
    i_exec_done   = 1'b0;
    i_jump        = 1'b0;
    i_return_pc   = 1'b0;
    i_end_of_code = 1'b0;
    if (exec_seen) begin
      i_exec_done   = 1'b1;
      i_jump        = (o_op_code == OP_JMP);
      i_return_pc   = (o_op_code == OP_RET);
      i_end_of_code = (o_op_code == OP_END);
    end
    exec_seen = o_execute && i_reset_n;
    if (mm_cnt > 0) begin
      i_mm_busy = 1'b1;
      mm_cnt--;
    end else begin
      i_mm_busy = 1'b0;
    end
    if (i_exec_done && (o_op_code == OP_STORE_WORD)) mm_cnt = store_busy;
  end

  // Monitor: every new fetch request is scored against the expected address queue.
  always @(negedge clk) begin
    if (o_imem_req && !req_prev) begin
      fetch_t.push_back(cyc);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL fetch_addr: got %0h, expected no fetch", o_imem_addr);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_imem_addr == e) n_pass++;
        else $display("FAIL fetch_addr: got %0h, expected %0h", o_imem_addr, e);
      end
    end
    if (o_execute) exec_count++;
    req_prev = o_imem_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %s: %0h ok", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = {OP_ADD, 16'h0000};
    fetch_t.delete();
    exec_count = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!o_halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!o_halted) begin
      n_total++;
      $display("FAIL halt_timeout: halted=%0b after %0d cycles, expected 1", o_halted, budget);
    end
  endtask

  task automatic chk_latency(input int exp_lat);
    for (int k = 1; k < fetch_t.size(); k++)
      chk($sformatf("latency%0d", k), fetch_t[k] - fetch_t[k-1], exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    clear_prog();
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
    chk("rst_pc", o_pc, 0);
    chk("rst_req", o_imem_req, 0);
    chk("rst_busy_halt_err_exec", {o_busy, o_halted, o_stack_err, o_execute}, 0);
    chk("rst_opregs", {o_op_code, o_operand1, o_operand2}, 0);

    // Sequential: three ADDs then END at 3.
    clear_prog();
    imem[3] = {OP_END, 16'h0000};
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    pulse_start();
    chk("seq_busy", o_busy, 1);
    wait_halt(100);
    chk("seq_halted", o_halted, 1);
    chk("seq_pc", o_pc, 3);
    chk("seq_execs", exec_count, 4);
    chk("seq_fetches", fetch_t.size(), 4);
    chk_latency(5);

    // Call / return.
    clear_prog();
    imem[2]     = {OP_JMP, 8'h10, 8'h00};
    imem[8'h10] = {OP_RET, 16'h0000};
    imem[3]     = {OP_END, 16'h0000};
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h03};
    pulse_start();
    wait_halt(100);
    chk("call_pc", o_pc, 3);
    chk("call_err", o_stack_err, 0);

    // Overflow: five nested calls with a four-entry stack.
    clear_prog();
    for (int i = 0; i < 5; i++) imem[i] = {OP_JMP, 8'(i + 1), 8'h00};
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start();
    wait_halt(100);
    chk("ovf_err", o_stack_err, 1);
    chk("ovf_halted", o_halted, 1);
    chk("ovf_pc", o_pc, 4);

    // Underflow, then restart clears the error.
    clear_prog();
    imem[0] = {OP_RET, 16'h0000};
    exp_q = '{8'h00};
    pulse_start();
    wait_halt(100);
    chk("udf_err", o_stack_err, 1);
    chk("udf_pc", o_pc, 0);
    imem[0] = {OP_END, 16'h0000};
    exp_q = '{8'h00};
    pulse_start();
    chk("restart_err_clr", o_stack_err, 0);
    chk("restart_halted_clr", o_halted, 0);
    wait_halt(100);
    chk("restart_err", o_stack_err, 0);

    // Memory stall: STORE with 4 busy cycles, LOAD with none.
    clear_prog();
    imem[0] = {OP_STORE_WORD, 16'h0000};
    imem[1] = {OP_LOAD_WORD, 16'h0000};
    imem[2] = {OP_END, 16'h0000};
    exp_q = '{8'h00, 8'h01, 8'h02};
    pulse_start();
    wait_halt(100);
    chk("mem_pc", o_pc, 2);
    chk("mem_fetches", fetch_t.size(), 3);
    if (fetch_t.size() == 3) begin
      chk("store_latency", fetch_t[1] - fetch_t[0], 10);
      chk("load_latency", fetch_t[2] - fetch_t[1], 6);
    end

    // PC wrap: call to 0xFF, sequential step lands on 0x00 (now END).
    clear_prog();
    imem[0] = {OP_JMP, 8'hFF, 8'h00};
    exp_q = '{8'h00, 8'hFF, 8'h00};
    pulse_start();
    begin
      int n = 0;
      while (exec_count < 1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    imem[0] = {OP_END, 16'h0000};
    wait_halt(100);
    chk("wrap_pc", o_pc, 0);
    chk("wrap_err", o_stack_err, 0);

    // Reset while stuck in FETCH at PC 2.
    clear_prog();
    ack_limit = 2;
    exp_q = '{8'h00, 8'h01, 8'h02};
    pulse_start();
    begin
      int n = 0;
      while (!(o_imem_req && o_imem_addr == 8'h02) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("stall_req", o_imem_req, 1);
    chk("stall_addr", o_imem_addr, 2);
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_req", o_imem_req, 0);
    chk("arst_pc", o_pc, 0);
    chk("arst_busy", o_busy, 0);
    @(negedge clk);
    i_reset_n = 1'b1;
    ack_limit = 256;
    repeat (2) @(negedge clk);
    chk("all_fetches_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
